// File: rtl/reg_write_decoder.sv
// reg_write_decoder: 5:32 destination decoder and write scoreboard for the register file write port.
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset, clears all state
//   issue_valid  in   issue stage presents a destination code
//   issue_code   in   destination register number
//   issue_ready  out  combinational, destination may be reserved (~busy[issue_code])
//   wb_valid     in   writeback of wb_code this cycle
//   wb_code      in   register being written back
//   wr_en        out  registered one-hot register-file write enable
//   busy         out  registered scoreboard, bit i = write to register i outstanding
//   pending      out  registered popcount of busy
//   wb_err       out  sticky, writeback seen to a non-busy register
// Optional macro R0_HARDWIRE_EN: register 0 is a hardwired zero and is never tracked or written.
module reg_write_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_code,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_code,
    output logic [31:0] wr_en,
    output logic [31:0] busy,
    output logic [5:0]  pending,
    output logic        wb_err
);
    logic [31:0] issue_oh, wb_oh, busy_next, wr_en_next;
    logic [5:0]  pending_next;
    logic        issue_set, wb_act, wb_clear, wb_err_next;

    assign issue_oh = 32'b1 << issue_code;
    assign wb_oh    = 32'b1 << wb_code;

    // No writeback bypass: a same-cycle writeback of a busy register still stalls the issue.
    assign issue_ready = ~busy[issue_code];

`ifdef R0_HARDWIRE_EN
    assign issue_set = issue_valid & issue_ready & (issue_code != 5'd0);
    assign wb_act    = wb_valid & (wb_code != 5'd0);
`else
    assign issue_set = issue_valid & issue_ready;
    assign wb_act    = wb_valid;
`endif

    assign wb_clear = wb_act & busy[wb_code];

    // Clear before set: an issue and a spurious writeback to the same idle register leave it busy.
    always_comb begin
        busy_next    = (busy & ~(wb_act ? wb_oh : 32'b0)) | (issue_set ? issue_oh : 32'b0);
        wr_en_next   = wb_act ? wb_oh : 32'b0;
        wb_err_next  = wb_err | (wb_act & ~busy[wb_code]);
        pending_next = (issue_set && !wb_clear) ? pending + 6'd1 :
                       (wb_clear && !issue_set) ? pending - 6'd1 : pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            wr_en   <= '0;
            pending <= '0;
            wb_err  <= 1'b0;
        end else begin
            busy    <= busy_next;
            wr_en   <= wr_en_next;
            pending <= pending_next;
            wb_err  <= wb_err_next;
        end
    end
endmodule

// File: tb/tb_reg_write_decoder.sv
// tb_reg_write_decoder: table-driven and scoreboard checks for reg_write_decoder.
module tb_reg_write_decoder;
    typedef struct {
        logic        iv;
        logic [4:0]  ic;
        logic        wv;
        logic [4:0]  wc;
        logic        rdy;
        logic [31:0] busy;
        logic [5:0]  pend;
        logic [31:0] wren;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_code = '0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_code = '0;
    logic [31:0] wr_en, busy;
    logic [5:0]  pending;
    logic        wb_err;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    reg_write_decoder dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_code(issue_code), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_code(wb_code),
        .wr_en(wr_en), .busy(busy), .pending(pending), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input logic [4:0] ic, input logic wv, input logic [4:0] wc,
                                input logic rdy, input logic [31:0] b, input logic [5:0] p,
                                input logic [31:0] w, input logic e);
        vec_t v;
        v.iv = iv; v.ic = ic; v.wv = wv; v.wc = wc; v.rdy = rdy;
        v.busy = b; v.pend = p; v.wren = w; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drives one cycle; the expected post-edge state is queued and retired after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        issue_valid = v.iv; issue_code = v.ic; wb_valid = v.wv; wb_code = v.wc;
        #1;
        chk("issue_ready", {31'b0, issue_ready}, {31'b0, v.rdy});
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = sb.pop_front();
            chk("busy", busy, e.busy);
            chk("pending", {26'b0, pending}, {26'b0, e.pend});
            chk("wr_en", wr_en, e.wren);
            chk("wb_err", {31'b0, wb_err}, {31'b0, e.err});
        end
    endtask

    initial begin
        logic [31:0] eb;
        logic [5:0]  ep;
        //            iv ic     wv wc     rdy busy          pend  wren          err
        tbl.push_back(mk(1, 5'd5,  0, 5'd0,  1, 32'h20,        6'd1, 32'h0,        0));
        tbl.push_back(mk(0, 5'd5,  0, 5'd0,  0, 32'h20,        6'd1, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0,  1, 5'd5,  1, 32'h0,         6'd0, 32'h20,       0));
        tbl.push_back(mk(0, 5'd0,  0, 5'd0,  1, 32'h0,         6'd0, 32'h0,        0));
        tbl.push_back(mk(1, 5'd9,  0, 5'd0,  1, 32'h200,       6'd1, 32'h0,        0));
        tbl.push_back(mk(1, 5'd9,  1, 5'd9,  0, 32'h0,         6'd0, 32'h200,      0));
        tbl.push_back(mk(1, 5'd9,  0, 5'd0,  1, 32'h200,       6'd1, 32'h0,        0));
        tbl.push_back(mk(0, 5'd0,  1, 5'd9,  1, 32'h0,         6'd0, 32'h200,      0));
        tbl.push_back(mk(1, 5'd3,  0, 5'd0,  1, 32'h8,         6'd1, 32'h0,        0));
        tbl.push_back(mk(1, 5'd31, 1, 5'd3,  1, 32'h8000_0000, 6'd1, 32'h8,        0));
        tbl.push_back(mk(0, 5'd0,  1, 5'd31, 1, 32'h0,         6'd0, 32'h8000_0000, 0));
        tbl.push_back(mk(0, 5'd0,  1, 5'd17, 1, 32'h0,         6'd0, 32'h2_0000,   1));
        tbl.push_back(mk(0, 5'd0,  0, 5'd0,  1, 32'h0,         6'd0, 32'h0,        1));
        tbl.push_back(mk(1, 5'd4,  1, 5'd6,  1, 32'h10,        6'd1, 32'h40,       1));
        tbl.push_back(mk(0, 5'd0,  1, 5'd4,  1, 32'h0,         6'd0, 32'h10,       1));
        tbl.push_back(mk(1, 5'd1,  0, 5'd0,  1, 32'h2,         6'd1, 32'h0,        1));
        tbl.push_back(mk(1, 5'd2,  0, 5'd0,  1, 32'h6,         6'd2, 32'h0,        1));
        tbl.push_back(mk(0, 5'd0,  1, 5'd1,  1, 32'h4,         6'd1, 32'h2,        1));
        tbl.push_back(mk(0, 5'd0,  1, 5'd2,  1, 32'h0,         6'd0, 32'h4,        1));
        tbl.push_back(mk(1, 5'd7,  1, 5'd7,  1, 32'h80,        6'd1, 32'h80,       1));
        tbl.push_back(mk(0, 5'd0,  1, 5'd7,  1, 32'h0,         6'd0, 32'h80,       1));

        // Reset state.
        #2;
        chk("rst_busy", busy, 32'h0);
        chk("rst_wr_en", wr_en, 32'h0);
        chk("rst_pending", {26'b0, pending}, 32'h0);
        chk("rst_ready", {31'b0, issue_ready}, 32'h1);
        #10 reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Asynchronous reset mid-stream with busy = 0x12 and wb_err already set.
        apply(mk(1, 5'd1, 0, 5'd0, 1, 32'h2,  6'd1, 32'h0, 1));
        apply(mk(1, 5'd4, 1, 5'd20, 1, 32'h12, 6'd2, 32'h0010_0000, 1));
        issue_valid = 1'b0; wb_valid = 1'b0; issue_code = 5'd4;
        #2 reset = 1'b1;
        #1;
        chk("async_busy", busy, 32'h0);
        chk("async_wr_en", wr_en, 32'h0);
        chk("async_pending", {26'b0, pending}, 32'h0);
        chk("async_wb_err", {31'b0, wb_err}, 32'h0);
        chk("async_ready", {31'b0, issue_ready}, 32'h1);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill the whole scoreboard.
        eb = '0; ep = '0;
        for (int i = 0; i < 32; i++) begin
`ifdef R0_HARDWIRE_EN
            if (i != 0) begin eb[i] = 1'b1; ep = ep + 6'd1; end
`else
            eb[i] = 1'b1; ep = ep + 6'd1;
`endif
            apply(mk(1, i[4:0], 0, 5'd0, 1, eb, ep, 32'h0, 0));
        end
`ifdef R0_HARDWIRE_EN
        chk("full_busy", busy, 32'hFFFF_FFFE);
        chk("full_pending", {26'b0, pending}, 32'd31);
        apply(mk(0, 5'd0, 1, 5'd0, 1, 32'hFFFF_FFFE, 6'd31, 32'h0, 0));
`else
        chk("full_busy", busy, 32'hFFFF_FFFF);
        chk("full_pending", {26'b0, pending}, 32'd32);
        apply(mk(0, 5'd0, 1, 5'd0, 0, 32'hFFFF_FFFE, 6'd31, 32'h1, 0));
`endif
        apply(mk(0, 5'd0, 1, 5'd31, 1, 32'h7FFF_FFFE, 6'd30, 32'h8000_0000, 0));

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
